// File: rtl/taus_pkg.sv
// Shared constants, state type and seed helpers for the
// multi-channel Tausworthe uniform random generator.
package taus_pkg;

  // Component 0 shifts: a (left), b (right), c (masked left)
  localparam int unsigned SH0_A = 13;
  localparam int unsigned SH0_B = 19;
  localparam int unsigned SH0_C = 12;

  localparam int unsigned SH1_A = 2;
  localparam int unsigned SH1_B = 25;
  localparam int unsigned SH1_C = 4;

  localparam int unsigned SH2_A = 3;
  localparam int unsigned SH2_B = 11;
  localparam int unsigned SH2_C = 17;

  localparam logic [31:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK2 = 32'hFFFF_FFF0;

  // A component below its minimum would degenerate the sequence
  localparam logic [31:0] MIN0 = 32'd2;
  localparam logic [31:0] MIN1 = 32'd8;
  localparam logic [31:0] MIN2 = 32'd16;

  localparam logic [31:0] SUB0 = 32'h2;
  localparam logic [31:0] SUB1 = 32'h8;
  localparam logic [31:0] SUB2 = 32'h10;

  // Golden-ratio constant decorrelating per-channel seeds
  localparam logic [31:0] SPREAD = 32'h9E37_79B9;

  typedef enum logic {
    UNSEEDED = 1'b0,
    RUN      = 1'b1
  } state_t;

  function automatic logic [31:0] fix_seed(
    input logic [31:0] v,
    input logic [31:0] min,
    input logic [31:0] sub
  );
    return (v < min) ? sub : v;
  endfunction

  // c * SPREAD modulo 2^32
  function automatic logic [31:0] chan_spread(input int c);
    logic [63:0] p;
    p = 64'(c) * 64'(SPREAD);
    return p[31:0];
  endfunction

endpackage

// File: rtl/taus_urng_mc_step.sv
// Combinational Tausworthe step for one channel.
// Ports: q0..q2 current state, n0..n2 next state, r sample.
module taus_step
  import taus_pkg::*;
(
  input  logic [31:0] q0,
  input  logic [31:0] q1,
  input  logic [31:0] q2,
  output logic [31:0] n0,
  output logic [31:0] n1,
  output logic [31:0] n2,
  output logic [31:0] r
);

  assign n0 = ((q0 & MASK0) << SH0_C)
            ^ (((q0 << SH0_A) ^ q0) >> SH0_B);
  assign n1 = ((q1 & MASK1) << SH1_C)
            ^ (((q1 << SH1_A) ^ q1) >> SH1_B);
  assign n2 = ((q2 & MASK2) << SH2_C)
            ^ (((q2 << SH2_A) ^ q2) >> SH2_B);

  assign r = n0 ^ n1 ^ n2;

endmodule

// File: rtl/taus_urng_mc.sv
// NUM_CH lockstep Tausworthe generators behind a
// valid/ready output with seed load and sample counter.
// Ports: clk, reset (async high), s0..s2 seeds,
// seed_load, out_data/out_valid/out_ready stream,
// seeded status, sample_cnt accepted-set count.
module taus_urng_mc
  import taus_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int OUT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             s0,
  input  logic [31:0]             s1,
  input  logic [31:0]             s2,
  input  logic                    seed_load,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    seeded,
  output logic [31:0]             sample_cnt
);

  state_t      state;
  logic [31:0] q0 [NUM_CH];
  logic [31:0] q1 [NUM_CH];
  logic [31:0] q2 [NUM_CH];
  logic [31:0] n0 [NUM_CH];
  logic [31:0] n1 [NUM_CH];
  logic [31:0] n2 [NUM_CH];
  logic [31:0] r  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    taus_step u_step (
      .q0 (q0[c]),
      .q1 (q1[c]),
      .q2 (q2[c]),
      .n0 (n0[c]),
      .n1 (n1[c]),
      .n2 (n2[c]),
      .r  (r[c])
    );
  end

  // Seed load has priority over any stream handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= UNSEEDED;
      seeded     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      sample_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        q0[c] <= '0;
        q1[c] <= '0;
        q2[c] <= '0;
      end
    end else if (seed_load) begin
      state     <= RUN;
      seeded    <= 1'b1;
      out_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        q0[c] <= fix_seed(s0 ^ chan_spread(c),
                          MIN0, SUB0);
        q1[c] <= fix_seed(s1 ^ chan_spread(c),
                          MIN1, SUB1);
        q2[c] <= fix_seed(s2 ^ chan_spread(c),
                          MIN2, SUB2);
      end
    end else begin
      unique case (state)
        UNSEEDED: begin
          out_valid <= 1'b0;
        end
        RUN: begin
          if (!out_valid || out_ready) begin
            if (out_valid)
              sample_cnt <= sample_cnt + 32'd1;
            out_valid <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
              q0[c] <= n0[c];
              q1[c] <= n1[c];
              q2[c] <= n2[c];
              out_data[c*OUT_W +: OUT_W] <=
                r[c][31 -: OUT_W];
            end
          end
        end
        default: begin
          state <= UNSEEDED;
        end
      endcase
    end
  end

endmodule
